// File: rtl/mips_avalon_arbiter.sv
// Two-master Avalon-MM arbiter: instruction fetch (i_) and data load/store (d_)
// share one downstream memory port. The FSM grants one side per transfer and
// the owning side's handshake is forwarded combinationally.
module mips_avalon_arbiter #(
   parameter int unsigned DATA_PRIORITY  = 0,
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic        clk,
   input  logic        reset,
   // instruction fetch master
   input  logic [31:0] i_address,
   input  logic        i_read,
   output logic        i_waitrequest,
   output logic [31:0] i_readdata,
   // data load/store master
   input  logic [31:0] d_address,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_writedata,
   input  logic [3:0]  d_byteenable,
   output logic        d_waitrequest,
   output logic [31:0] d_readdata,
   // downstream memory port
   output logic [31:0] address,
   output logic        read,
   output logic        write,
   output logic [31:0] writedata,
   output logic [3:0]  byteenable,
   input  logic        waitrequest,
   input  logic [31:0] readdata,
   // observability
   output logic        grant_data,
   output logic        bus_error
);

   localparam int unsigned CNT_W = 16;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_GRANT_I = 2'd1,
      S_GRANT_D = 2'd2
   } state_t;

   state_t             r_state;
   state_t             w_state_next;
   logic               r_last_grant;   // 0 = I, 1 = D
   logic [CNT_W-1:0]   r_wait_cnt;
   logic               r_bus_error;

   logic               w_req_i;
   logic               w_req_d;
   logic               w_req_granted;
   logic               w_stall;
   logic               w_done;
   logic [CNT_W-1:0]   w_cnt_inc;

   assign w_req_i = i_read;
   assign w_req_d = d_read | d_write;

   // Request of whichever side currently owns the bus
   always_comb begin
      w_req_granted = 1'b0;
      case (r_state)
         S_GRANT_I: w_req_granted = w_req_i;
         S_GRANT_D: w_req_granted = w_req_d;
         default:   w_req_granted = 1'b0;
      endcase
   end

   assign w_stall   = w_req_granted & waitrequest;
   assign w_done    = w_req_granted & ~waitrequest;
   assign w_cnt_inc = (r_wait_cnt == '1) ? r_wait_cnt : r_wait_cnt + CNT_W'(1);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_state_next;
   end

   // Next-state: arbitration in IDLE, release on completion or dropped request
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_req_i && w_req_d)
               w_state_next = ((DATA_PRIORITY != 0) || !r_last_grant) ? S_GRANT_D : S_GRANT_I;
            else if (w_req_i)
               w_state_next = S_GRANT_I;
            else if (w_req_d)
               w_state_next = S_GRANT_D;
         end
         S_GRANT_I, S_GRANT_D: begin
            if (!w_req_granted || !waitrequest) w_state_next = S_IDLE;
         end
         default: w_state_next = S_IDLE;
      endcase
   end

   // Fairness history, wait-state counter and sticky timeout flag
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_last_grant <= 1'b1;
         r_wait_cnt   <= '0;
         r_bus_error  <= 1'b0;
      end else begin
         if (r_state == S_IDLE && w_state_next != S_IDLE) begin
            r_wait_cnt <= '0;
         end else if (w_stall) begin
            r_wait_cnt <= w_cnt_inc;
            if (32'(w_cnt_inc) >= TIMEOUT_CYCLES) r_bus_error <= 1'b1;
         end
         if (w_done) r_last_grant <= (r_state == S_GRANT_D);
      end
   end

   // Output mux: forward the owning side, park everything else
   always_comb begin
      address       = '0;
      read          = 1'b0;
      write         = 1'b0;
      writedata     = '0;
      byteenable    = '0;
      i_waitrequest = 1'b1;
      d_waitrequest = 1'b1;
      i_readdata    = '0;
      d_readdata    = '0;
      grant_data    = 1'b0;
      case (r_state)
         S_GRANT_I: begin
            address       = i_address;
            read          = i_read;
            byteenable    = 4'b1111;
            i_waitrequest = waitrequest;
            i_readdata    = readdata;
         end
         S_GRANT_D: begin
            address       = d_address;
            read          = d_read;
            write         = d_write;
            writedata     = d_writedata;
            byteenable    = d_byteenable;
            d_waitrequest = waitrequest;
            d_readdata    = readdata;
            grant_data    = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus_error = r_bus_error;

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed bench: u0 is round-robin with a short timeout, u1 is data-priority
// with the default timeout. Both see the same stimulus.
module tb_mips_avalon_arbiter;

   logic        clk;
   logic        reset;
   logic [31:0] i_address;
   logic        i_read;
   logic [31:0] d_address;
   logic        d_read;
   logic        d_write;
   logic [31:0] d_writedata;
   logic [3:0]  d_byteenable;
   logic        waitrequest;
   logic [31:0] readdata;

   logic        a_i_waitrequest, a_d_waitrequest, a_read, a_write, a_grant_data, a_bus_error;
   logic [31:0] a_i_readdata, a_d_readdata, a_address, a_writedata;
   logic [3:0]  a_byteenable;
   logic        b_i_waitrequest, b_d_waitrequest, b_read, b_write, b_grant_data, b_bus_error;
   logic [31:0] b_i_readdata, b_d_readdata, b_address, b_writedata;
   logic [3:0]  b_byteenable;

   int vec_cnt;
   int err_cnt;

   mips_avalon_arbiter #(.DATA_PRIORITY(0), .TIMEOUT_CYCLES(4)) u0 (
      .clk(clk), .reset(reset),
      .i_address(i_address), .i_read(i_read),
      .i_waitrequest(a_i_waitrequest), .i_readdata(a_i_readdata),
      .d_address(d_address), .d_read(d_read), .d_write(d_write),
      .d_writedata(d_writedata), .d_byteenable(d_byteenable),
      .d_waitrequest(a_d_waitrequest), .d_readdata(a_d_readdata),
      .address(a_address), .read(a_read), .write(a_write),
      .writedata(a_writedata), .byteenable(a_byteenable),
      .waitrequest(waitrequest), .readdata(readdata),
      .grant_data(a_grant_data), .bus_error(a_bus_error)
   );

   mips_avalon_arbiter #(.DATA_PRIORITY(1), .TIMEOUT_CYCLES(1024)) u1 (
      .clk(clk), .reset(reset),
      .i_address(i_address), .i_read(i_read),
      .i_waitrequest(b_i_waitrequest), .i_readdata(b_i_readdata),
      .d_address(d_address), .d_read(d_read), .d_write(d_write),
      .d_writedata(d_writedata), .d_byteenable(d_byteenable),
      .d_waitrequest(b_d_waitrequest), .d_readdata(b_d_readdata),
      .address(b_address), .read(b_read), .write(b_write),
      .writedata(b_writedata), .byteenable(b_byteenable),
      .waitrequest(waitrequest), .readdata(readdata),
      .grant_data(b_grant_data), .bus_error(b_bus_error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec_cnt++;
      assert (obs === exp)
      else begin
         err_cnt++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   initial begin
      vec_cnt      = 0;
      err_cnt      = 0;
      reset        = 1'b0;
      i_address    = '0;
      i_read       = 1'b0;
      d_address    = '0;
      d_read       = 1'b0;
      d_write      = 1'b0;
      d_writedata  = '0;
      d_byteenable = '0;
      waitrequest  = 1'b0;
      readdata     = 32'h55AA55AA;

      // reset state
      #1;
      chk("rst_address",  a_address,       32'h0);
      chk("rst_read",     a_read,          32'h0);
      chk("rst_write",    a_write,         32'h0);
      chk("rst_wdata",    a_writedata,     32'h0);
      chk("rst_be",       a_byteenable,    32'h0);
      chk("rst_grant_d",  a_grant_data,    32'h0);
      chk("rst_i_wait",   a_i_waitrequest, 32'h1);
      chk("rst_d_wait",   a_d_waitrequest, 32'h1);
      chk("rst_i_rdata",  a_i_readdata,    32'h0);
      chk("rst_d_rdata",  a_d_readdata,    32'h0);
      chk("rst_bus_err",  a_bus_error,     32'h0);

      // single instruction fetch, zero-wait memory
      @(negedge clk);
      reset       = 1'b1;
      i_address   = 32'hBFC00000;
      i_read      = 1'b1;
      waitrequest = 1'b0;
      readdata    = 32'h24020005;
      #1;
      chk("fetch_idle_read",  a_read,          32'h0);
      chk("fetch_idle_iwait", a_i_waitrequest, 32'h1);
      @(negedge clk); #1;
      chk("fetch_address",    a_address,       32'hBFC00000);
      chk("fetch_read",       a_read,          32'h1);
      chk("fetch_write",      a_write,         32'h0);
      chk("fetch_be",         a_byteenable,    32'hF);
      chk("fetch_wdata",      a_writedata,     32'h0);
      chk("fetch_iwait",      a_i_waitrequest, 32'h0);
      chk("fetch_irdata",     a_i_readdata,    32'h24020005);
      chk("fetch_dwait",      a_d_waitrequest, 32'h1);
      chk("fetch_drdata",     a_d_readdata,    32'h0);
      chk("fetch_grant_d",    a_grant_data,    32'h0);
      @(negedge clk);
      i_read = 1'b0;
      #1;
      chk("fetch_done_read",  a_read,          32'h0);
      chk("fetch_done_iwait", a_i_waitrequest, 32'h1);
      chk("fetch_done_irdat", a_i_readdata,    32'h0);
      chk("fetch_done_addr",  a_address,       32'h0);

      // reset asserted in the middle of a stalled data write
      @(negedge clk);
      d_address    = 32'h00001000;
      d_write      = 1'b1;
      d_writedata  = 32'hDEADBEEF;
      d_byteenable = 4'b0011;
      waitrequest  = 1'b1;
      @(negedge clk); #1;
      chk("wr_write",    a_write,         32'h1);
      chk("wr_grant_d",  a_grant_data,    32'h1);
      chk("wr_dwait",    a_d_waitrequest, 32'h1);
      chk("wr_address",  a_address,       32'h00001000);
      chk("wr_be",       a_byteenable,    32'h3);
      chk("wr_wdata",    a_writedata,     32'hDEADBEEF);
      reset = 1'b0;
      #1;
      chk("abort_write",   a_write,         32'h0);
      chk("abort_dwait",   a_d_waitrequest, 32'h1);
      chk("abort_grant_d", a_grant_data,    32'h0);
      chk("abort_write_b", b_write,         32'h0);
      d_write     = 1'b0;
      waitrequest = 1'b0;

      // continuous contention: u0 alternates I,D,...; u1 always D
      @(negedge clk);
      reset     = 1'b1;
      i_address = 32'h00000400;
      i_read    = 1'b1;
      d_write   = 1'b1;
      readdata  = 32'h11111111;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk); #1;
         case (k % 4)
            0: begin
               chk($sformatf("cont%0d_a_grant", k), a_grant_data,    32'h0);
               chk($sformatf("cont%0d_a_read",  k), a_read,          32'h1);
               chk($sformatf("cont%0d_a_write", k), a_write,         32'h0);
               chk($sformatf("cont%0d_a_addr",  k), a_address,       32'h00000400);
               chk($sformatf("cont%0d_a_iwait", k), a_i_waitrequest, 32'h0);
               chk($sformatf("cont%0d_a_dwait", k), a_d_waitrequest, 32'h1);
            end
            2: begin
               chk($sformatf("cont%0d_a_grant", k), a_grant_data,    32'h1);
               chk($sformatf("cont%0d_a_write", k), a_write,         32'h1);
               chk($sformatf("cont%0d_a_be",    k), a_byteenable,    32'h3);
               chk($sformatf("cont%0d_a_addr",  k), a_address,       32'h00001000);
               chk($sformatf("cont%0d_a_iwait", k), a_i_waitrequest, 32'h1);
               chk($sformatf("cont%0d_a_dwait", k), a_d_waitrequest, 32'h0);
            end
            default: begin
               chk($sformatf("cont%0d_a_grant", k), a_grant_data,    32'h0);
               chk($sformatf("cont%0d_a_read",  k), a_read,          32'h0);
               chk($sformatf("cont%0d_a_write", k), a_write,         32'h0);
               chk($sformatf("cont%0d_a_iwait", k), a_i_waitrequest, 32'h1);
               chk($sformatf("cont%0d_a_dwait", k), a_d_waitrequest, 32'h1);
            end
         endcase
         chk($sformatf("cont%0d_b_grant", k), b_grant_data,    (k % 2 == 0) ? 32'h1 : 32'h0);
         chk($sformatf("cont%0d_b_write", k), b_write,         (k % 2 == 0) ? 32'h1 : 32'h0);
         chk($sformatf("cont%0d_b_iwait", k), b_i_waitrequest, 32'h1);
      end

      // u0 now holds GRANT_I; fetch drops its request before completing
      @(negedge clk);
      i_read  = 1'b0;
      d_write = 1'b0;
      #1;
      chk("drop_read", a_read, 32'h0);
      @(negedge clk); #1;
      chk("drop_iwait",   a_i_waitrequest, 32'h1);
      chk("drop_bus_err", a_bus_error,     32'h0);
      // abandoned grant leaves history at D, so I wins the next contention
      i_read  = 1'b1;
      d_write = 1'b1;
      @(negedge clk); #1;
      chk("drop_next_grant", a_grant_data, 32'h0);
      chk("drop_next_read",  a_read,       32'h1);
      i_read  = 1'b0;
      d_write = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // data read with three wait states
      d_address    = 32'h00002000;
      d_read       = 1'b1;
      d_byteenable = 4'b1111;
      waitrequest  = 1'b1;
      readdata     = 32'hCAFE0001;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk); #1;
         chk($sformatf("ws%0d_dwait",  c), a_d_waitrequest, 32'h1);
         chk($sformatf("ws%0d_iwait",  c), a_i_waitrequest, 32'h1);
         chk($sformatf("ws%0d_grant",  c), a_grant_data,    32'h1);
         chk($sformatf("ws%0d_drdata", c), a_d_readdata,    32'hCAFE0001);
         chk($sformatf("ws%0d_irdata", c), a_i_readdata,    32'h0);
      end
      @(negedge clk);
      waitrequest = 1'b0;
      #1;
      chk("ws_done_dwait",   a_d_waitrequest, 32'h0);
      chk("ws_done_read",    a_read,          32'h1);
      chk("ws_done_bus_err", a_bus_error,     32'h0);
      @(negedge clk);
      d_read = 1'b0;
      #1;
      chk("ws_idle_grant",   a_grant_data,    32'h0);
      chk("ws_idle_dwait",   a_d_waitrequest, 32'h1);
      chk("ws_idle_bus_err", a_bus_error,     32'h0);

      // timeout: u0 flags after its 4th wait cycle, flag is sticky
      @(negedge clk);
      d_read      = 1'b1;
      waitrequest = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         chk($sformatf("to%0d_a_bus_err", c), a_bus_error, (c >= 4) ? 32'h1 : 32'h0);
         chk($sformatf("to%0d_b_bus_err", c), b_bus_error, 32'h0);
         chk($sformatf("to%0d_a_dwait",   c), a_d_waitrequest, 32'h1);
      end
      waitrequest = 1'b0;
      #1;
      chk("to_resp_dwait", a_d_waitrequest, 32'h0);
      chk("to_resp_grant", a_grant_data,    32'h1);
      @(negedge clk);
      d_read = 1'b0;
      #1;
      chk("to_done_bus_err", a_bus_error,  32'h1);
      chk("to_done_grant",   a_grant_data, 32'h0);
      @(negedge clk); #1;
      chk("to_idle_bus_err", a_bus_error, 32'h1);
      reset = 1'b0;
      #1;
      chk("to_rst_bus_err", a_bus_error, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
